// File: rtl/ps_fetch_if.sv
// ps_fetch_if: instruction-memory request/response bus of the fetch stage.
//   imem_req    : request valid (fetch -> memory)
//   imem_add    : word-aligned request address (fetch -> memory)
//   imem_gnt    : request accepted when imem_req & imem_gnt (memory -> fetch)
//   imem_rvalid : in-order response valid, >=1 cycle after grant (memory -> fetch)
//   imem_data   : response word (memory -> fetch)
// master modport is the fetch stage, slave modport is the memory.
`timescale 1ns/1ps
interface ps_fetch_if;
    logic        imem_req;
    logic [31:0] imem_add;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_data;

    modport master (
        output imem_req, imem_add,
        input  imem_gnt, imem_rvalid, imem_data
    );

    modport slave (
        input  imem_req, imem_add,
        output imem_gnt, imem_rvalid, imem_data
    );
endinterface

// File: rtl/ps_fetch.sv
// ps_fetch: instruction fetch stage. Generates the fetch PC, issues in-order
// requests to instruction memory, buffers returned words in a DEPTH-entry
// prefetch queue and presents one instruction per cycle to decode.
// Optional static backward-taken/forward-not-taken prediction is compiled in
// when the macro PS_FETCH_BTFN_EN is defined.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   stall_de              : decode cannot accept; hold the output register
//   redirect_en/pc        : execute-stage redirect and its target
//   imem (master)         : instruction memory bus (see ps_fetch_if)
//   pc/instruction        : presented instruction and its address
//   vinst                 : presented instruction is valid
//   pinst                 : presented instruction was predicted taken
`timescale 1ns/1ps
module ps_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_de,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    ps_fetch_if.master  imem,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        vinst,
    output logic        pinst
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned OW = CW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;      // address of the next accepted response
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] q_count;
    logic [PW-1:0] q_head;
    logic [PW-1:0] q_tail;
    logic [31:0]   q_pc   [DEPTH];
    logic [31:0]   q_word [DEPTH];
    logic          q_pred [DEPTH];

    logic [OW-1:0] occupancy;
    logic [CW-1:0] out_next;
    logic          grant;
    logic          accept;
    logic          load;
    logic          pop;
    logic          push;
    logic          resp_pred;
    logic [31:0]   pred_target;

    // Every outstanding request owns a queue slot, so a response can
    // always be pushed.
    assign occupancy     = {1'b0, outstanding} + {1'b0, q_count};
    assign imem.imem_req = !reset && !redirect_en && (occupancy < OW'(DEPTH));
    assign imem.imem_add = fetch_pc;

    assign grant    = imem.imem_req && imem.imem_gnt;
    assign out_next = outstanding + CW'(grant) - CW'(imem.imem_rvalid);
    // The response in a redirect cycle belongs to the old path.
    assign accept   = imem.imem_rvalid && !redirect_en && (drop_cnt == '0);
    assign load     = !stall_de || !vinst;
    assign pop      = !redirect_en && load && (q_count != '0);
    // With an empty queue and a loading output, the response bypasses the queue.
    assign push     = accept && !(load && (q_count == '0));

`ifdef PS_FETCH_BTFN_EN
    logic        is_branch;
    logic        is_jal;
    logic [31:0] b_imm;
    logic [31:0] j_imm;

    always_comb begin
        is_branch   = (imem.imem_data[6:0] == 7'b1100011) && imem.imem_data[31];
        is_jal      = (imem.imem_data[6:0] == 7'b1101111);
        b_imm       = {{20{imem.imem_data[31]}}, imem.imem_data[7],
                       imem.imem_data[30:25], imem.imem_data[11:8], 1'b0};
        j_imm       = {{12{imem.imem_data[31]}}, imem.imem_data[19:12],
                       imem.imem_data[20], imem.imem_data[30:21], 1'b0};
        resp_pred   = is_branch || is_jal;
        pred_target = resp_pc + (is_jal ? j_imm : b_imm);
    end
`else
    always_comb begin
        resp_pred   = 1'b0;
        pred_target = '0;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            q_count     <= '0;
            q_head      <= '0;
            q_tail      <= '0;
            pc          <= RESET_PC;
            instruction <= '0;
            vinst       <= 1'b0;
            pinst       <= 1'b0;
        end else begin
            outstanding <= out_next;
            if (redirect_en) begin
                fetch_pc    <= redirect_pc;
                resp_pc     <= redirect_pc;
                drop_cnt    <= outstanding - CW'(imem.imem_rvalid);
                q_count     <= '0;
                q_head      <= '0;
                q_tail      <= '0;
                instruction <= '0;
                vinst       <= 1'b0;
                pinst       <= 1'b0;
            end else begin
                if (accept && resp_pred) begin
                    // Everything still in flight (including a grant this
                    // cycle) is on the fall-through path and is discarded.
                    fetch_pc <= pred_target;
                    resp_pc  <= pred_target;
                    drop_cnt <= out_next;
                end else begin
                    if (grant)
                        fetch_pc <= fetch_pc + 32'd4;
                    if (accept)
                        resp_pc <= resp_pc + 32'd4;
                    if (imem.imem_rvalid && (drop_cnt != '0))
                        drop_cnt <= drop_cnt - CW'(1);
                end

                if (push)
                    q_tail <= q_tail + PW'(1);
                if (pop)
                    q_head <= q_head + PW'(1);
                q_count <= q_count + CW'(push) - CW'(pop);

                if (load) begin
                    if (q_count != '0) begin
                        pc          <= q_pc[q_head];
                        instruction <= q_word[q_head];
                        pinst       <= q_pred[q_head];
                        vinst       <= 1'b1;
                    end else if (accept) begin
                        pc          <= resp_pc;
                        instruction <= imem.imem_data;
                        pinst       <= resp_pred;
                        vinst       <= 1'b1;
                    end else begin
                        instruction <= '0;
                        pinst       <= 1'b0;
                        vinst       <= 1'b0;
                    end
                end
            end
        end
    end

    // Queue storage needs no reset; validity is carried by q_count.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[q_tail]   <= resp_pc;
            q_word[q_tail] <= imem.imem_data;
            q_pred[q_tail] <= resp_pred;
        end
    end
endmodule

// File: tb/tb_ps_fetch.sv
`timescale 1ns/1ps
module tb_ps_fetch;
    logic        clk = 1'b0;
    logic        reset;
    logic        stall_de;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        vinst;
    logic        pinst;

    ps_fetch_if bus ();

    ps_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall_de    (stall_de),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .imem        (bus),
        .pc          (pc),
        .instruction (instruction),
        .vinst       (vinst),
        .pinst       (pinst)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory responder configuration
    int unsigned lat_min   = 1;
    int unsigned lat_max   = 1;
    int unsigned gnt_pct   = 100;
    bit          branch_on = 1'b0;
    int unsigned cyc       = 0;

    typedef struct {
        logic [31:0] add;
        int unsigned due;
    } rsp_t;
    rsp_t rq[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (branch_on && a == 32'h20)
            return 32'hFE00_08E3;   // beq x0,x0,-16
        return {a[19:0], 12'h013};
    endfunction

    // In-order memory: grant sampled mid-cycle, response no earlier than
    // the chosen latency, one response per cycle, cleared on reset.
    initial begin
        logic        hs;
        logic [31:0] ha;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_data   = '0;
        forever begin
            @(negedge clk);
            hs = bus.imem_req && bus.imem_gnt;
            ha = bus.imem_add;
            @(posedge clk);
            cyc++;
            if (reset)
                rq.delete();
            else if (hs)
                rq.push_back('{ha, cyc - 1 + $urandom_range(lat_max, lat_min)});
            #1;
            if (!reset && rq.size() != 0 && rq[0].due <= cyc) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_data   = mem_word(rq[0].add);
                void'(rq.pop_front());
            end else begin
                bus.imem_rvalid = 1'b0;
                bus.imem_data   = '0;
            end
            bus.imem_gnt = ($urandom_range(99, 0) < gnt_pct);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        stall_de    = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_pc;
        int          accepted;

        // ---- reset values
        reset = 1'b1; stall_de = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
        @(negedge clk);
        chk("rst_req",   32'(bus.imem_req), 32'd0);
        chk("rst_add",   bus.imem_add,      32'h0);
        chk("rst_pc",    pc,                32'h0);
        chk("rst_instr", instruction,       32'h0);
        chk("rst_vinst", 32'(vinst),        32'd0);
        chk("rst_pinst", 32'(pinst),        32'd0);

        // ---- sequential fetch, 1-cycle memory
        do_reset();
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            @(negedge clk);
            chk("seq_req", 32'(bus.imem_req), 32'd1);
            chk("seq_add", bus.imem_add, 32'(4 * (c - 1)));
            if (c >= 3) begin
                chk("seq_vinst", 32'(vinst), 32'd1);
                chk("seq_pc",    pc, 32'(4 * (c - 3)));
                chk("seq_instr", instruction, mem_word(32'(4 * (c - 3))));
            end else begin
                chk("seq_vinst0", 32'(vinst), 32'd0);
            end
        end

        // ---- stall for 5 cycles while the queue fills
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            stall_de = (c >= 7 && c <= 11);
            @(negedge clk);
            if (c >= 7 && c <= 12) begin
                chk("stall_pc",    pc, 32'h10);
                chk("stall_instr", instruction, mem_word(32'h10));
                chk("stall_vinst", 32'(vinst), 32'd1);
            end
            if (c == 8 || c == 9)
                chk("stall_req_fill", 32'(bus.imem_req), 32'd1);
            if (c >= 10 && c <= 12) begin
                chk("stall_req_full", 32'(bus.imem_req), 32'd0);
                chk("stall_add_hold", bus.imem_add, 32'h24);
            end
            if (c == 13)
                chk("stall_req_resume", 32'(bus.imem_req), 32'd1);
            if (c >= 13) begin
                chk("release_vinst", 32'(vinst), 32'd1);
                chk("release_pc",    pc, 32'(20 + 4 * (c - 13)));
                chk("release_instr", instruction, mem_word(32'(20 + 4 * (c - 13))));
            end
        end
        stall_de = 1'b0;

        // ---- redirect with 3 outstanding (4-cycle memory)
        lat_min = 4; lat_max = 4;
        do_reset();
        for (int c = 1; c <= 13; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            redirect_en = (c == 4);
            redirect_pc = (c == 4) ? 32'h100 : 32'h0;
            @(negedge clk);
            if (c == 4)
                chk("redir_req_blocked", 32'(bus.imem_req), 32'd0);
            if (c == 5) begin
                chk("redir_req_new", 32'(bus.imem_req), 32'd1);
                chk("redir_add_new", bus.imem_add, 32'h100);
            end
            if (c == 9)
                chk("redir_req_limit", 32'(bus.imem_req), 32'd0);
            if (c >= 5 && c <= 9) begin
                chk("redir_vinst0", 32'(vinst), 32'd0);
                chk("redir_instr0", instruction, 32'h0);
                chk("redir_pc_hold", pc, 32'h0);
            end
            if (c >= 10) begin
                chk("redir_vinst", 32'(vinst), 32'd1);
                chk("redir_pc",    pc, 32'(32'h100 + 4 * (c - 10)));
                chk("redir_instr", instruction, mem_word(32'(32'h100 + 4 * (c - 10))));
            end
        end
        redirect_en = 1'b0;

        // ---- redirect together with stall and a response
        lat_min = 1; lat_max = 1;
        do_reset();
        for (int c = 1; c <= 9; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            redirect_en = (c == 5);
            stall_de    = (c == 5);
            redirect_pc = (c == 5) ? 32'h200 : 32'h0;
            @(negedge clk);
            if (c == 5) begin
                chk("rs_pc_before", pc, 32'h8);
                chk("rs_req", 32'(bus.imem_req), 32'd0);
            end
            if (c == 6) begin
                chk("rs_vinst0", 32'(vinst), 32'd0);
                chk("rs_instr0", instruction, 32'h0);
                chk("rs_pc_hold", pc, 32'h8);
                chk("rs_add", bus.imem_add, 32'h200);
            end
            if (c == 7)
                chk("rs_vinst0b", 32'(vinst), 32'd0);
            if (c >= 8) begin
                chk("rs_vinst", 32'(vinst), 32'd1);
                chk("rs_pc", pc, 32'(32'h200 + 4 * (c - 8)));
            end
        end
        redirect_en = 1'b0; stall_de = 1'b0;

        // ---- backward branch at 0x20
        branch_on = 1'b1;
        do_reset();
        for (int c = 1; c <= 13; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            @(negedge clk);
            if (c == 10) begin
                chk("br_prev_pc", pc, 32'h1C);
                chk("br_prev_pinst", 32'(pinst), 32'd0);
            end
            if (c == 11) begin
                chk("br_pc", pc, 32'h20);
                chk("br_instr", instruction, 32'hFE00_08E3);
`ifdef PS_FETCH_BTFN_EN
                chk("br_pinst", 32'(pinst), 32'd1);
                chk("br_add", bus.imem_add, 32'h10);
`else
                chk("br_pinst", 32'(pinst), 32'd0);
                chk("br_add", bus.imem_add, 32'h28);
`endif
            end
            if (c == 12) begin
`ifdef PS_FETCH_BTFN_EN
                chk("br_gap_vinst", 32'(vinst), 32'd0);
`else
                chk("br_next_vinst", 32'(vinst), 32'd1);
                chk("br_next_pc", pc, 32'h24);
`endif
            end
            if (c == 13) begin
                chk("br_after_vinst", 32'(vinst), 32'd1);
`ifdef PS_FETCH_BTFN_EN
                chk("br_after_pc", pc, 32'h10);
`else
                chk("br_after_pc", pc, 32'h28);
`endif
            end
        end
        branch_on = 1'b0;

        // ---- random grant, latency and stall: in-order, gap-free stream
        lat_min = 1; lat_max = 4; gnt_pct = 70;
        do_reset();
        exp_pc   = 32'h0;
        accepted = 0;
        for (int c = 1; c <= 300; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            stall_de = ($urandom_range(3, 0) == 0);
            @(negedge clk);
            if (vinst) begin
                chk("rnd_pc", pc, exp_pc);
                chk("rnd_instr", instruction, mem_word(exp_pc));
                if (!stall_de) begin
                    exp_pc = exp_pc + 32'd4;
                    accepted++;
                end
            end else begin
                chk("rnd_instr0", instruction, 32'h0);
            end
        end
        chk("rnd_progress", 32'(accepted > 40), 32'd1);

        // ---- asynchronous reset mid-operation
        stall_de = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("arst_vinst", 32'(vinst), 32'd0);
        chk("arst_pc",    pc, 32'h0);
        chk("arst_req",   32'(bus.imem_req), 32'd0);
        chk("arst_add",   bus.imem_add, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
